line_fetch_ctrl: RTL and testbench
==================================

LINE_FETCH_CTRL -- requirements
Module: line_fetch_ctrl

Interface
REQ-001 Parameter ADDR_W, default 24: framebuffer word-address width.
REQ-002 Parameter WORDS_PER_LINE, default 160: 32-bit words per active line (4 px/word, 640 px).
REQ-003 Parameter BURST_LEN, default 16: words per read burst; WORDS_PER_LINE SHALL be a multiple of BURST_LEN.
REQ-004 clk_pix  in  1  pixel clock; the only clock.
REQ-005 rst_n  in  1  reset; asynchronous and active-low.
REQ-006 sx  in  10  horizontal position from the 640x480 timing generator, 0..799.
REQ-007 sy  in  10  vertical position from the timing generator, 0..524.
REQ-008 fb_base  in  ADDR_W  framebuffer base word address.
REQ-009 req_valid  out  1  burst read request valid.
REQ-010 req_ready  in  1  memory accepts request.
REQ-011 req_addr  out  ADDR_W  burst start word address.
REQ-012 rd_valid  in  1  one returned data word this cycle.
REQ-013 lb_we  out  1  line-buffer write enable.
REQ-014 lb_waddr  out  8  line-buffer word index, 0..WORDS_PER_LINE-1.
REQ-015 lb_bank  out  1  ping-pong bank select; equals bit 0 of the target line.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 underrun  out  1  sticky fetch-deadline miss flag.

Function
REQ-018 FSM states: IDLE, REQ, WAIT_DATA.
REQ-019 Trigger: in IDLE, when sx==640 and the next line is active (sy<479 gives target sy+1; sy==524 gives target 0), go to REQ; otherwise remain in IDLE.
REQ-020 On a trigger, target line, burst counter (0) and lb_waddr (0) SHALL be loaded, and lb_bank SHALL be set from the target line.
REQ-021 fb_base SHALL be latched only on a trigger whose target line is 0, so it is stable for the whole frame.
REQ-022 req_addr = latched base + target*WORDS_PER_LINE + burst*BURST_LEN, modulo 2^ADDR_W.
REQ-023 REQ: req_valid=1, and req_valid and req_addr SHALL hold steady until the cycle req_valid&&req_ready; then go to WAIT_DATA.
REQ-024 Only one burst SHALL be outstanding at a time.
REQ-025 WAIT_DATA: each rd_valid SHALL assert lb_we for the same cycle with the current lb_waddr, then increment lb_waddr.
REQ-026 After BURST_LEN words are received, go to REQ with burst+1 if bursts remain; otherwise go to IDLE.
REQ-027 rd_valid outside WAIT_DATA SHALL be ignored: lb_we stays 0.
REQ-028 Deadline: if sx==799 and state!=IDLE, underrun SHALL be set to 1.
REQ-029 After a deadline miss, the current burst handshake and its data SHALL complete, no further bursts SHALL be issued, and the FSM then goes to IDLE.
REQ-030 If req_ready arrives in the deadline cycle, the handshake counts and that burst's data SHALL be accepted.
REQ-031 A trigger for the next line SHALL be taken only from IDLE.

Reset
REQ-032 While rst_n==0: state IDLE, and req_valid, req_addr, lb_we, lb_waddr, lb_bank, busy, underrun, counters and latched base all 0.
REQ-033 Deassertion of rst_n mid-fetch SHALL restart cleanly at the next trigger; underrun SHALL be cleared only by reset.

Configuration
REQ-034 Macro LINE_FETCH_UNDERRUN_EN defined: the deadline logic of REQ-028..REQ-030 is compiled in.
REQ-035 Macro LINE_FETCH_UNDERRUN_EN undefined: underrun is tied 0 and a fetch runs to completion regardless of sx.

Structure
REQ-036 Package line_fetch_pkg SHALL hold H_ACTIVE=640, LINE_END=799, V_ACTIVE_END=479, SCREEN_END=524, the defaults of WORDS_PER_LINE and BURST_LEN, and the state enum typedef.
REQ-037 The block SHALL be a single module with no sub-module; the address arithmetic is inline.

Verification
REQ-038 fb_base=0x010000, sy=0, sx reaching 640 -> req_addr=0x0100A0, then 0x0100B0 … 0x010130; 10 bursts; lb_bank=1.
REQ-039 sy=524, sx=640 -> target line 0, req_addr=0x010000, fb_base latched; a later fb_base change has no effect until the next frame.
REQ-040 sy=479..523 at sx=640 -> no req_valid.
REQ-041 req_ready held low 5 cycles -> req_valid and req_addr stable, and rd_valid during REQ gives no lb_we.
REQ-042 Memory stalls so the 5th burst is incomplete at sx==799 -> underrun=1, current burst finishes, no 6th request, IDLE; with the macro undefined, all 10 bursts complete and underrun=0.
REQ-043 rst_n pulsed low during WAIT_DATA -> all outputs 0 asynchronously; normal fetch resumes at the next sx==640.

Source files
------------

// File: rtl/line_fetch_pkg.sv
// ----------------------------------------------------------------------------
// line_fetch_pkg
// Shared constants and types for the scan-line fetch controller.
//   H_ACTIVE      first horizontal position after the active pixels (fetch trigger)
//   LINE_END      last horizontal position of a line (fetch deadline)
//   V_ACTIVE_END  last active line of the 640x480 frame
//   SCREEN_END    last line of the frame including vertical blanking
//   WORDS_PER_LINE_DEF / BURST_LEN_DEF  default geometry for line_fetch_ctrl
//   fetch_state_t controller state encoding
// ----------------------------------------------------------------------------
package line_fetch_pkg;

    localparam int H_ACTIVE           = 640;
    localparam int LINE_END           = 799;
    localparam int V_ACTIVE_END       = 479;
    localparam int SCREEN_END         = 524;

    localparam int WORDS_PER_LINE_DEF = 160;
    localparam int BURST_LEN_DEF      = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DATA = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/line_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// line_fetch_ctrl
// Fetches the next visible scan line from the framebuffer into one bank of a
// ping-pong line buffer. At sx==640 of a line whose successor is active, the
// controller issues WORDS_PER_LINE/BURST_LEN read bursts, one outstanding at a
// time, and writes each returned word into the line buffer.
//
// Ports
//   clk_pix    in   pixel clock (only clock)
//   rst_n      in   asynchronous active-low reset
//   sx, sy     in   timing-generator position (0..799, 0..524)
//   fb_base    in   framebuffer base word address, sampled at frame start
//   req_valid  out  burst read request valid
//   req_ready  in   memory accepts request
//   req_addr   out  burst start word address
//   rd_valid   in   one returned data word this cycle
//   lb_we      out  line-buffer write enable (same cycle as rd_valid)
//   lb_waddr   out  line-buffer word index
//   lb_bank    out  ping-pong bank, bit 0 of the target line
//   busy       out  controller not idle
//   underrun   out  sticky fetch-deadline miss
//
// Build option
//   LINE_FETCH_UNDERRUN_EN  when defined, a fetch still running at sx==799
//                           sets underrun and stops after the current burst.
//                           When undefined, underrun is 0 and every fetch
//                           runs to completion.
// ----------------------------------------------------------------------------
module line_fetch_ctrl
    import line_fetch_pkg::*;
#(
    parameter int ADDR_W         = 24,
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
    parameter int BURST_LEN      = BURST_LEN_DEF
) (
    input  logic              clk_pix,
    input  logic              rst_n,
    input  logic [9:0]        sx,
    input  logic [9:0]        sy,
    input  logic [ADDR_W-1:0] fb_base,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              rd_valid,
    output logic              lb_we,
    output logic [7:0]        lb_waddr,
    output logic              lb_bank,
    output logic              busy,
    output logic              underrun
);

    localparam int NUM_BURSTS = WORDS_PER_LINE / BURST_LEN;
    localparam int BW         = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int BTW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    fetch_state_t      state;
    logic [BW-1:0]     burst;
    logic [BTW-1:0]    beat;
    logic [ADDR_W-1:0] base_q;

    logic              trigger;
    logic [9:0]        next_target;
    logic [ADDR_W-1:0] trig_base;
    logic [ADDR_W-1:0] trig_addr;
    logic              beat_last;
    logic              burst_last;
    logic              stop_fetch;

    // The line after 524 wraps to line 0; lines 479..523 have no active successor.
    assign next_target = (sy == 10'(SCREEN_END)) ? 10'd0 : (sy + 10'd1);
    assign trigger     = (state == IDLE) && (sx == 10'(H_ACTIVE)) &&
                         ((sy < 10'(V_ACTIVE_END)) || (sy == 10'(SCREEN_END)));

    // The frame-start fetch uses the live fb_base because it is latched in the
    // same cycle; every other line uses the value held for the frame.
    assign trig_base   = (next_target == 10'd0) ? fb_base : base_q;
    assign trig_addr   = trig_base + (ADDR_W'(next_target) * ADDR_W'(WORDS_PER_LINE));

    assign beat_last   = (beat == BTW'(BURST_LEN - 1));
    assign burst_last  = (burst == BW'(NUM_BURSTS - 1));

    assign lb_we       = (state == WAIT_DATA) && rd_valid;
    assign busy        = (state != IDLE);

`ifdef LINE_FETCH_UNDERRUN_EN
    logic deadline;
    logic underrun_q;
    logic abort_q;

    assign deadline   = (sx == 10'(LINE_END)) && (state != IDLE);
    // Include the deadline cycle itself so a burst ending exactly at sx==799
    // does not launch another one.
    assign stop_fetch = abort_q || deadline;
    assign underrun   = underrun_q;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
        end else if (deadline) begin
            underrun_q <= 1'b1;
            abort_q    <= 1'b1;
        end else if (trigger) begin
            abort_q    <= 1'b0;
        end
    end
`else
    assign stop_fetch = 1'b0;
    assign underrun   = 1'b0;
`endif

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            burst     <= '0;
            beat      <= '0;
            base_q    <= '0;
            req_valid <= 1'b0;
            req_addr  <= '0;
            lb_waddr  <= '0;
            lb_bank   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        burst     <= '0;
                        beat      <= '0;
                        lb_waddr  <= '0;
                        lb_bank   <= next_target[0];
                        if (next_target == 10'd0) begin
                            base_q <= fb_base;
                        end
                        req_addr  <= trig_addr;
                        req_valid <= 1'b1;
                        state     <= REQ;
                    end
                end

                REQ: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        state     <= WAIT_DATA;
                    end
                end

                WAIT_DATA: begin
                    if (rd_valid) begin
                        lb_waddr <= lb_waddr + 8'd1;
                        if (beat_last) begin
                            beat <= '0;
                            if (burst_last || stop_fetch) begin
                                state <= IDLE;
                            end else begin
                                // Bursts are contiguous, so the next start
                                // address is one burst further on.
                                burst     <= burst + BW'(1);
                                req_addr  <= req_addr + ADDR_W'(BURST_LEN);
                                req_valid <= 1'b1;
                                state     <= REQ;
                            end
                        end else begin
                            beat <= beat + BTW'(1);
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_line_fetch_ctrl
// Scoreboard bench for line_fetch_ctrl. Stimulus pushes the expected request
// addresses and line-buffer writes into queues; a monitor pops and compares
// them whenever the DUT hands over a request or writes a word. A behavioural
// memory answers requests with configurable ready lag, stalls and stray
// rd_valid pulses.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_line_fetch_ctrl;

    localparam int ADDR_W = 24;
    localparam int WPL    = 160;
    localparam int BL     = 16;

`ifdef LINE_FETCH_UNDERRUN_EN
    localparam int UR_BURSTS = 5;
    localparam int UR_FLAG   = 1;
`else
    localparam int UR_BURSTS = 10;
    localparam int UR_FLAG   = 0;
`endif

    logic              clk_pix = 1'b0;
    logic              rst_n;
    logic [9:0]        sx;
    logic [9:0]        sy;
    logic [ADDR_W-1:0] fb_base;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rd_valid;
    logic              lb_we;
    logic [7:0]        lb_waddr;
    logic              lb_bank;
    logic              busy;
    logic              underrun;

    line_fetch_ctrl #(
        .ADDR_W         (ADDR_W),
        .WORDS_PER_LINE (WPL),
        .BURST_LEN      (BL)
    ) dut (
        .clk_pix   (clk_pix),
        .rst_n     (rst_n),
        .sx        (sx),
        .sy        (sy),
        .fb_base   (fb_base),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rd_valid  (rd_valid),
        .lb_we     (lb_we),
        .lb_waddr  (lb_waddr),
        .lb_bank   (lb_bank),
        .busy      (busy),
        .underrun  (underrun)
    );

    always #5 clk_pix = ~clk_pix;

    int n_tests = 0;
    int n_fail  = 0;

    logic [ADDR_W-1:0] exp_req[$];
    logic [8:0]        exp_wr[$];

    // Memory model knobs
    int ready_lag    = 0;
    bit stray_rd     = 1'b0;
    int stall_burst  = -1;
    int stall_cycles = 0;
    int m_burst      = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    // Memory: decide at the falling edge from settled DUT outputs, drive just
    // after the next rising edge.
    initial begin : memory
        int  m_state;
        int  m_lag;
        int  m_beats;
        int  m_wait;
        bit  n_ready;
        bit  n_rd;
        m_state = 0; m_lag = 0; m_beats = 0; m_wait = 0;
        req_ready = 1'b0;
        rd_valid  = 1'b0;
        forever begin
            @(negedge clk_pix);
            n_ready = 1'b0;
            n_rd    = 1'b0;
            if (!rst_n) begin
                m_state = 0;
                m_lag   = 0;
            end else if (m_state == 0) begin
                n_rd = stray_rd;
                if (req_valid && req_ready) begin
                    m_state = 1;
                    m_lag   = 0;
                    m_beats = BL;
                    m_wait  = (m_burst == stall_burst) ? stall_cycles : 0;
                    m_burst++;
                    if (m_wait > 0) begin
                        m_wait--;
                        n_rd = 1'b0;
                    end else begin
                        n_rd = 1'b1;
                    end
                end else if (req_valid) begin
                    if (m_lag >= ready_lag) n_ready = 1'b1;
                    else m_lag++;
                end
            end else begin
                if (rd_valid) m_beats--;
                if (m_beats == 0) begin
                    m_state = 0;
                    n_rd    = stray_rd;
                end else if (m_wait > 0) begin
                    m_wait--;
                    n_rd = 1'b0;
                end else begin
                    n_rd = 1'b1;
                end
            end
            @(posedge clk_pix);
            #1;
            req_ready = n_ready;
            rd_valid  = n_rd;
        end
    end

    // Monitor / scoreboard
    initial begin : monitor
        logic [ADDR_W-1:0] ea;
        logic [8:0]        ew;
        forever begin
            @(negedge clk_pix);
            if (rst_n) begin
                if (req_valid && req_ready) begin
                    if (exp_req.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL req_unexpected: got addr 0x%0h, expected no request", req_addr);
                    end else begin
                        ea = exp_req.pop_front();
                        check("req_addr", 32'(req_addr), 32'(ea));
                    end
                end
                if (lb_we) begin
                    if (exp_wr.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL wr_unexpected: got bank %0d idx %0d, expected no write", lb_bank, lb_waddr);
                    end else begin
                        ew = exp_wr.pop_front();
                        check("lb_write", 32'({lb_bank, lb_waddr}), 32'(ew));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish, expected finish before 400us");
        $fatal(1);
    end

    task automatic push_line(input int y, input logic [ADDR_W-1:0] base, input int nbursts);
        int tgt;
        logic [ADDR_W-1:0] a;
        tgt = (y == 524) ? 0 : y + 1;
        for (int b = 0; b < nbursts; b++) begin
            a = base + ADDR_W'(tgt * WPL + b * BL);
            exp_req.push_back(a);
        end
        for (int w = 0; w < nbursts * BL; w++) begin
            exp_wr.push_back({tgt[0], w[7:0]});
        end
    endtask

    task automatic start_line(input int y, input bit adv);
        m_burst = 0;
        sx = 10'd640;
        sy = 10'(y);
        tick();
        sx = adv ? 10'd641 : 10'd700;
    endtask

    task automatic wait_idle(input bit adv);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            tick();
            if (adv) sx = (sx == 10'd799) ? 10'd0 : sx + 10'd1;
            if (!busy) done = 1'b1;
        end
        check("fetch_done", 32'(done), 32'd1);
        sx = 10'd700;
        check("req_left", 32'(exp_req.size()), 32'd0);
        check("wr_left", 32'(exp_wr.size()), 32'd0);
    endtask

    task automatic fetch_line(input int y, input logic [ADDR_W-1:0] base, input int nbursts, input bit adv);
        push_line(y, base, nbursts);
        start_line(y, adv);
        wait_idle(adv);
    endtask

    initial begin : stimulus
        bit reached;
        rst_n   = 1'b0;
        sx      = 10'd0;
        sy      = 10'd0;
        fb_base = 24'h010000;
        tick(); tick(); tick();

        // Reset state
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_req_addr",  32'(req_addr),  32'd0);
        check("rst_lb_we",     32'(lb_we),     32'd0);
        check("rst_lb_waddr",  32'(lb_waddr),  32'd0);
        check("rst_lb_bank",   32'(lb_bank),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_underrun",  32'(underrun),  32'd0);
        rst_n = 1'b1;
        tick();

        // Frame start latches fb_base; then line 1 at 0x0100A0..0x010130, bank 1
        fetch_line(524, 24'h010000, 10, 1'b0);
        fetch_line(0,   24'h010000, 10, 1'b0);

        // A mid-frame base change is ignored; last active target line 479
        fb_base = 24'h020000;
        fetch_line(5,   24'h010000, 10, 1'b0);
        fetch_line(478, 24'h010000, 10, 1'b0);

        // Lines 479..523 have no active successor
        for (int y = 479; y <= 523; y++) begin
            sx = 10'd640;
            sy = 10'(y);
            tick();
            check("no_trig_valid", 32'(req_valid), 32'd0);
            sx = 10'd700;
        end
        check("no_trig_busy", 32'(busy), 32'd0);

        // Ready held low for 5 cycles with stray rd_valid around the request
        ready_lag = 5;
        stray_rd  = 1'b1;
        push_line(10, 24'h010000, 10);
        start_line(10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_pix);
            check("lag_req_valid", 32'(req_valid), 32'd1);
            check("lag_req_addr",  32'(req_addr),  32'h0106E0);
            check("lag_lb_we",     32'(lb_we),     32'd0);
        end
        wait_idle(1'b0);
        @(negedge clk_pix);
        check("idle_rd_valid_seen", 32'(rd_valid), 32'd1);
        check("idle_lb_we",         32'(lb_we),     32'd0);
        ready_lag = 0;
        stray_rd  = 1'b0;
        tick(); tick();

        // Memory stalls burst 4 past sx==799
        stall_burst  = 4;
        stall_cycles = 100;
        fetch_line(20, 24'h010000, UR_BURSTS, 1'b1);
        check("underrun_flag", 32'(underrun), 32'(UR_FLAG));
        stall_burst = -1;
        tick(); tick();

        // Asynchronous reset during WAIT_DATA
        push_line(30, 24'h010000, 10);
        start_line(30, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            tick();
            if (lb_waddr >= 8'd3) reached = 1'b1;
        end
        check("reset_wait_data_reached", 32'(reached), 32'd1);
        #2;
        rst_n = 1'b0;
        exp_req.delete();
        exp_wr.delete();
        #1;
        check("arst_req_valid", 32'(req_valid), 32'd0);
        check("arst_req_addr",  32'(req_addr),  32'd0);
        check("arst_lb_we",     32'(lb_we),     32'd0);
        check("arst_lb_waddr",  32'(lb_waddr),  32'd0);
        check("arst_lb_bank",   32'(lb_bank),   32'd0);
        check("arst_busy",      32'(busy),      32'd0);
        check("arst_underrun",  32'(underrun),  32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Latched base was cleared by reset: line 1 starts at 0x0000A0
        fetch_line(0, 24'h000000, 10, 1'b0);
        check("post_reset_underrun", 32'(underrun), 32'd0);
        // Next frame picks up the new base
        fetch_line(524, 24'h020000, 10, 1'b0);

        check("final_req_left", 32'(exp_req.size()), 32'd0);
        check("final_wr_left",  32'(exp_wr.size()),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
